// File: rtl/nn_mem_pkg.sv
// Shared types and constants for the MNIST network ROM access blocks.
package nn_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } rsr_state_t;

  localparam int unsigned RSR_FIFO_DEPTH = 2;
  localparam int unsigned RSR_CNT_W      = $clog2(RSR_FIFO_DEPTH + 1);

endpackage

// File: rtl/rsr_fifo2.sv
// Two-entry synchronous FIFO buffering ROM words ahead of the output stream.
module rsr_fifo2
  import nn_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid,
  output logic [RSR_CNT_W-1:0]  count
);

  logic [DATA_WIDTH-1:0] mem_q [RSR_FIFO_DEPTH];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [RSR_CNT_W-1:0]  count_q;

  // Storage and pointers; the caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RSR_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + RSR_CNT_W'(push) - RSR_CNT_W'(pop);
    end
  end

  assign head_data  = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign count      = count_q;

endmodule

// File: rtl/rom_stream_reader.sv
// Issues sequential reads to a single-port ROM with one-cycle read latency and
// streams the returned words over valid/ready with a last flag.
module rom_stream_reader
  import nn_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_a,
  output logic                  rom_we,
  output logic [DATA_WIDTH-1:0] rom_d,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  rsr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      issue_left_q, issue_left_d;
  logic [LEN_W-1:0]      beat_left_q, beat_left_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [RSR_CNT_W-1:0]  fifo_count;
  logic                  pop_c;
  logic [2:0]            occ_c;

  assign pop_c = fifo_valid & out_ready;
  // Occupancy the FIFO will have once the in-flight read lands.
  assign occ_c = 3'(fifo_count) + 3'(pending_q) - 3'(pop_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      pending_q    <= pending_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    pending_d    = 1'b0;
    done_d       = 1'b0;

    if (pop_c) begin
      beat_left_d = beat_left_q - LEN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          issue_left_d = length;
          beat_left_d  = length;
          state_d      = (length == '0) ? FLUSH : STREAM;
        end
      end
      STREAM: begin
        if (occ_c < 3'd2) begin
          pending_d    = 1'b1;
          addr_d       = addr_q + ADDR_WIDTH'(1);
          issue_left_d = issue_left_q - LEN_W'(1);
          if (issue_left_q == LEN_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if ((beat_left_q == '0) || (pop_c && (beat_left_q == LEN_W'(1)))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // busy covers the done cycle even though the FSM is already back in IDLE.
    busy_d = (state_d != IDLE) | done_d;
  end

  rsr_fifo2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_q),
    .push_data (rom_q),
    .pop       (pop_c),
    .head_data (fifo_data),
    .head_valid(fifo_valid),
    .count     (fifo_count)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign rom_a     = addr_q;
  assign rom_we    = 1'b0;
  assign rom_d     = '0;
  assign out_data  = fifo_data;
  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid & (beat_left_q == LEN_W'(1));

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader against a ROM model with mem[i]=i.
module tb_rom_stream_reader;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        busy, done, rom_we, out_valid, out_last;
  logic        out_ready = 1'b1;
  logic [15:0] rom_a, rom_d, rom_q, out_data;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int beats_seen = 0;
  int dones_seen = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data = '0;
  logic [5:0]  pat = 6'b101001;

  rom_stream_reader #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .rom_a(rom_a), .rom_we(rom_we), .rom_d(rom_d),
    .rom_q(rom_q), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Registered ROM: word i holds value i.
  always @(posedge clk) begin
    rom_q <= rom_a;
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_data));
      end
      hold_pend = out_valid & ~out_ready;
      hold_data = out_data;
      if (out_last && !out_valid) chk("last_without_valid", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("last", 32'(out_last), 32'(e.last));
        end
        if (beats_seen == 0) first_pop_cyc = cyc;
        if (out_last) last_pop_cyc = cyc;
        beats_seen++;
      end
      if (done) dones_seen++;
    end
  end

  // mode 0: ready high; 1: ready toggles 1,0,0,1,0,1; 2: ready high plus a start while busy.
  task automatic run_cmd(input logic [15:0] base, input logic [16:0] len, input int mode);
    int  n;
    int  l;
    bit  got;
    l = int'(len);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len; out_ready = 1'b1;
    for (int i = 0; i < l; i++) begin
      beat_t e;
      e.data = base + 16'(i);
      e.last = (i == l - 1);
      exp_q.push_back(e);
    end
    beats_seen = 0;
    @(posedge clk); #1;
    n = cyc;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      out_ready = (mode == 1) ? pat[i % 6] : 1'b1;
      if (mode == 2 && i == 2) begin
        start = 1'b1; base_addr = 16'h0200; length = 17'd2;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (i == 0) chk("busy_rise", 32'(busy), 32'd1);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("busy_in_done", 32'(busy), 32'd1);
      if (l != 0) chk("done_lag", 32'(cyc - last_pop_cyc), 32'd1);
      else        chk("len0_done_cyc", 32'(cyc - n), 32'd1);
      chk("beat_count", 32'(beats_seen), 32'(l));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      if (mode != 1 && l > 1) chk("span", 32'(last_pop_cyc - first_pop_cyc), 32'(l - 1));
    end
    exp_q.delete();
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_fall", 32'(busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit reached;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_rom_we", 32'(rom_we), 32'd0);
    chk("rst_rom_a", 32'(rom_a), 32'd0);
    chk("rst_rom_d", 32'(rom_d), 32'd0);
    rst_n = 1'b1;

    run_cmd(16'h0010, 17'd4, 0);
    run_cmd(16'h0010, 17'd4, 1);
    run_cmd(16'hFFFE, 17'd4, 0);
    run_cmd(16'h0030, 17'd0, 0);
    run_cmd(16'h0100, 17'd4, 2);

    // Abort a command of 8 after 2 beats.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h0040; length = 17'd8; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      beat_t e;
      e.data = 16'h0040 + 16'(i);
      e.last = (i == 7);
      exp_q.push_back(e);
    end
    beats_seen = 0;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (beats_seen >= 2) reached = 1'b1;
    end
    chk("abort_two_beats", 32'(reached), 32'd1);
    d0 = dones_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rom_a", 32'(rom_a), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(dones_seen - d0), 32'd0);
    run_cmd(16'h0020, 17'd3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
